// File: rtl/swc_pkt_mem_write_pump_if.sv
// Port-side and memory-side signals of the MPM write pump.
// The overflow_cnt_o member exists only when SWC_PUMP_OVERFLOW_CNT_EN is defined.
interface swc_pkt_mem_write_pump_if #(
  parameter int unsigned g_data_width      = 16,
  parameter int unsigned g_ctrl_width      = 16,
  parameter int unsigned g_mpm_mult        = 16,
  parameter int unsigned g_page_addr_width = 10,
  parameter int unsigned g_offset_width    = 2
) ();

  logic                                              sync_i;
  logic                                              pagereq_i;
  logic [g_page_addr_width-1:0]                      pageaddr_i;
  logic                                              pageend_o;
  logic [g_data_width-1:0]                           data_i;
  logic [g_ctrl_width-1:0]                           ctrl_i;
  logic                                              drdy_i;
  logic                                              full_o;
  logic                                              flush_i;
  logic                                              mem_we_o;
  logic [g_page_addr_width+g_offset_width-1:0]       mem_addr_o;
  logic [g_mpm_mult*(g_data_width+g_ctrl_width)-1:0] mem_data_o;
  logic [g_mpm_mult-1:0]                             mem_mask_o;
`ifdef SWC_PUMP_OVERFLOW_CNT_EN
  logic [15:0]                                       overflow_cnt_o;
`endif

  // Master drives words and slot/page control; the pump is the slave.
  modport master (
`ifdef SWC_PUMP_OVERFLOW_CNT_EN
    input  overflow_cnt_o,
`endif
    output sync_i, pagereq_i, pageaddr_i, data_i, ctrl_i, drdy_i, flush_i,
    input  pageend_o, full_o, mem_we_o, mem_addr_o, mem_data_o, mem_mask_o
  );

  modport slave (
`ifdef SWC_PUMP_OVERFLOW_CNT_EN
    output overflow_cnt_o,
`endif
    input  sync_i, pagereq_i, pageaddr_i, data_i, ctrl_i, drdy_i, flush_i,
    output pageend_o, full_o, mem_we_o, mem_addr_o, mem_data_o, mem_mask_o
  );

endinterface

// File: rtl/swc_pkt_mem_write_pump.sv
// Per-port MPM write pump: packs words into a line and commits it in the port's sync slot.
// Optional dropped-word counter enabled by defining SWC_PUMP_OVERFLOW_CNT_EN.
module swc_pkt_mem_write_pump #(
  parameter int unsigned g_data_width      = 16,
  parameter int unsigned g_ctrl_width      = 16,
  parameter int unsigned g_mpm_mult        = 16,
  parameter int unsigned g_page_addr_width = 10,
  parameter int unsigned g_lines_per_page  = 4,
  parameter int unsigned g_offset_width    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  swc_pkt_mem_write_pump_if.slave  pif
);

  localparam int unsigned WordW = g_data_width + g_ctrl_width;
  localparam int unsigned CntW  = (g_mpm_mult > 1) ? $clog2(g_mpm_mult) : 1;
  localparam int unsigned AddrW = g_page_addr_width + g_offset_width;
  localparam logic [CntW-1:0]           LastLane = CntW'(g_mpm_mult - 1);
  localparam logic [g_offset_width-1:0] LastOff  = g_offset_width'(g_lines_per_page - 1);

  typedef enum logic {ST_FILL, ST_PEND} state_e;

  state_e                                 state_q, state_d;
  logic                                   full_q, full_d;
  logic [CntW-1:0]                        cnt_q, cnt_d;
  logic [g_mpm_mult-1:0][WordW-1:0]       line_q, line_d;
  logic [g_mpm_mult-1:0]                  mask_q, mask_d;
  logic [g_page_addr_width-1:0]           page_q, page_d;
  logic [g_offset_width-1:0]              offset_q, offset_d;
  logic                                   page_valid_q, page_valid_d;
  logic                                   mem_we_q, mem_we_d;
  logic [AddrW-1:0]                       mem_addr_q, mem_addr_d;
  logic [g_mpm_mult-1:0][WordW-1:0]       mem_data_q, mem_data_d;
  logic [g_mpm_mult-1:0]                  mem_mask_q, mem_mask_d;
  logic                                   pageend_q, pageend_d;

  logic accept;
  logic commit;

  // full_q mirrors the pending state, so accept and commit never coincide.
  assign accept = pif.drdy_i & ~full_q;
  assign commit = (state_q == ST_PEND) & pif.sync_i & page_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_FILL;
      full_q       <= 1'b0;
      cnt_q        <= '0;
      line_q       <= '0;
      mask_q       <= '0;
      page_q       <= '0;
      offset_q     <= '0;
      page_valid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_mask_q   <= '0;
      pageend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      mask_q       <= mask_d;
      page_q       <= page_d;
      offset_q     <= offset_d;
      page_valid_q <= page_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_mask_q   <= mem_mask_d;
      pageend_q    <= pageend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    mask_d       = mask_q;
    page_d       = page_q;
    offset_d     = offset_q;
    page_valid_d = page_valid_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_mask_d   = mem_mask_q;
    pageend_d    = 1'b0;

    if (accept) begin
      line_d[cnt_q] = {pif.ctrl_i, pif.data_i};
      mask_d[cnt_q] = 1'b1;
      if (cnt_q == LastLane) begin
        state_d = ST_PEND;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    // Flush looks at the count after this edge's accept so that word is included.
    if (pif.flush_i && (cnt_d != '0)) begin
      state_d = ST_PEND;
      cnt_d   = '0;
    end

    if (commit) begin
      state_d    = ST_FILL;
      mem_we_d   = 1'b1;
      mem_addr_d = {page_q, offset_q};
      mem_data_d = line_q;
      mem_mask_d = mask_q;
      mask_d     = '0;
      if (offset_q == LastOff) begin
        offset_d     = '0;
        page_valid_d = 1'b0;
        pageend_d    = 1'b1;
      end else begin
        offset_d = offset_q + g_offset_width'(1);
      end
    end

    // A page request overrides the post-commit page state; the commit already used the old one.
    if (pif.pagereq_i) begin
      page_d       = pif.pageaddr_i;
      page_valid_d = 1'b1;
      offset_d     = '0;
    end

    full_d = (state_d == ST_PEND);
  end

`ifdef SWC_PUMP_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_cnt_q <= '0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  // Saturating count of words offered while the pump was full.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (pif.drdy_i && full_q && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  assign pif.overflow_cnt_o = ovf_cnt_q;
`endif

  assign pif.full_o     = full_q;
  assign pif.pageend_o  = pageend_q;
  assign pif.mem_we_o   = mem_we_q;
  assign pif.mem_addr_o = mem_addr_q;
  assign pif.mem_data_o = mem_data_q;
  assign pif.mem_mask_o = mem_mask_q;

endmodule
